// File: rtl/priority_hit_scanner_pkg.sv
// Shared definitions for the sequential hit scanner and any replacement of the
// old combinational priority encoder.
package priority_hit_scanner_pkg;

  localparam int unsigned IDX_W_DEF     = 7;
  localparam int unsigned NONE_CODE_DEF = (1 << IDX_W_DEF) - 1;
  localparam int unsigned HITS_MAX      = NONE_CODE_DEF - 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // 1-based index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [IDX_W_DEF-1:0] lsb_index(input logic [HITS_MAX-1:0] vec);
    logic [IDX_W_DEF-1:0] idx;
    logic                 found;
    idx   = IDX_W_DEF'(NONE_CODE_DEF);
    found = 1'b0;
    for (int unsigned i = 0; i < HITS_MAX; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W_DEF'(i + 1);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_hit_scanner_lsb_index_enc.sv
// Combinational priority encoder: 1-based index of the lowest set bit, or the
// NONE code when the vector is empty.
module lsb_index_enc #(
  parameter int unsigned WIDTH     = 86,
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned NONE_CODE = (1 << IDX_W) - 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index
);

  logic found;

  always_comb begin
    index = IDX_W'(NONE_CODE);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i] && !found) begin
        index = IDX_W'(i + 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_hit_scanner.sv
// Serialises a hit vector into a stream of 1-based hit indices, lowest first,
// one beat per accepted cycle, with last/none flags and a beat counter.
module priority_hit_scanner
  import priority_hit_scanner_pkg::*;
#(
  parameter int unsigned WIDTH     = 86,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter int unsigned NONE_CODE = (1 << IDX_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_hits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_none,
  output logic [IDX_W-1:0] out_seq
);

  if ((1 << IDX_W) - 1 <= WIDTH) begin : g_bad_idx_w
    $error("IDX_W too small for WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] load_vec;
  logic [WIDTH-1:0] cleared;
  logic [WIDTH-1:0] enc_vec;
  logic [IDX_W-1:0] enc_index;

  function automatic logic single_bit(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // One encoder serves both the load vector (IDLE) and the post-clear vector (EMIT).
  always_comb begin
    load_vec = en ? in_hits : '0;
    cleared  = pending & (pending - 1'b1);
    enc_vec  = (state == IDLE) ? load_vec : cleared;
  end

  lsb_index_enc #(
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W),
    .NONE_CODE (NONE_CODE)
  ) u_enc (
    .vec   (enc_vec),
    .index (enc_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_index <= IDX_W'(NONE_CODE);
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_seq   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            state     <= EMIT;
            pending   <= load_vec;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_index <= enc_index;
            out_none  <= (load_vec == '0);
            out_last  <= (load_vec == '0) || single_bit(load_vec);
            out_seq   <= '0;
          end
        end
        EMIT: begin
          if (flush || (out_ready && out_last)) begin
            state     <= IDLE;
            pending   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= IDX_W'(NONE_CODE);
            out_last  <= 1'b0;
            out_none  <= 1'b0;
            out_seq   <= '0;
          end else if (out_ready) begin
            pending   <= cleared;
            out_index <= enc_index;
            out_none  <= 1'b0;
            out_last  <= single_bit(cleared);
            out_seq   <= out_seq + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_hit_scanner.sv
// Randomised and directed checks of the hit scanner against a queue-based
// model of the expected beat stream.
module tb_priority_hit_scanner;

  localparam int unsigned W    = 86;
  localparam int unsigned IW   = 7;
  localparam int unsigned NONE = 127;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_hits = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_none;
  logic [IW-1:0] out_seq;

  int checks = 0;
  int errors = 0;

  priority_hit_scanner #(.WIDTH(W), .IDX_W(IW), .NONE_CODE(NONE)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hits   (in_hits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_seq   (out_seq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: toggling ready, 2: random ready
  task automatic run_job(input logic [W-1:0] vec, input logic en_v, input int mode);
    int exp_idx[$];
    int n, k, cyc;
    logic rdy;
    for (int i = 0; i < int'(W); i++)
      if (en_v && vec[i]) exp_idx.push_back(i + 1);
    if (exp_idx.size() == 0) exp_idx.push_back(NONE);
    n = exp_idx.size();
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_out_valid", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_hits  = vec;
    en       = en_v;
    step();
    in_valid = 1'b0;
    en       = 1'($urandom);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 1000) begin
      chk("beat_valid", 32'(out_valid), 1);
      chk("beat_in_ready", 32'(in_ready), 0);
      chk("beat_index", 32'(out_index), 32'(exp_idx[k]));
      chk("beat_last", 32'(out_last), 32'(k == n - 1));
      chk("beat_none", 32'(out_none), 32'(exp_idx[k] == int'(NONE)));
      chk("beat_seq", 32'(out_seq), 32'(k));
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      in_hits   = rand_vec();
      step();
      if (rdy) k++;
      cyc++;
    end
    chk("job_complete", 32'(k), 32'(n));
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_seq", 32'(out_seq), 0);
  endtask

  initial begin
    logic [W-1:0] v;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_index", 32'(out_index), NONE);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_none", 32'(out_none), 0);
    chk("rst_seq", 32'(out_seq), 0);

    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[85] = 1'b1;
    run_job(v, 1'b1, 0);
    run_job('0, 1'b1, 0);
    v = '0; v[0] = 1'b1; v[5] = 1'b1;
    run_job(v, 1'b0, 0);
    run_job('1, 1'b1, 1);
    v = '0; v[7] = 1'b1;
    run_job(v, 1'b1, 0);

    // flush while index 4 is held with out_ready low
    v = '0; v[3] = 1'b1; v[40] = 1'b1;
    in_valid = 1'b1; in_hits = v; en = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fl_index", 32'(out_index), 4);
    chk("fl_valid", 32'(out_valid), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_after_valid", 32'(out_valid), 0);
    chk("fl_after_ready", 32'(in_ready), 1);
    chk("fl_after_seq", 32'(out_seq), 0);
    // flush in IDLE blocks a load
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_valid", 32'(out_valid), 0);
    chk("fl_idle_ready", 32'(in_ready), 1);
    v = '0; v[10] = 1'b1;
    run_job(v, 1'b1, 0);

    // reset after two beats of {1,2,3,4}
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1; v[4] = 1'b1;
    in_valid = 1'b1; in_hits = v; en = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rs_beat1", 32'(out_index), 2);
    step();
    chk("rs_beat2", 32'(out_index), 3);
    step();
    out_ready = 1'b0;
    chk("rs_beat3", 32'(out_index), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_in_ready", 32'(in_ready), 1);
    chk("rs_out_valid", 32'(out_valid), 0);
    chk("rs_index", 32'(out_index), NONE);
    chk("rs_seq", 32'(out_seq), 0);
    chk("rs_last", 32'(out_last), 0);
    run_job(v, 1'b1, 0);

    for (int j = 0; j < 8; j++) begin
      v = rand_vec() & rand_vec() & rand_vec();
      run_job(v, 1'($urandom_range(0, 7) != 0), 2);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
